// File: rtl/kyber_pkg.sv
// Shared Kyber constants and scheduler state type for the pointwise-multiply slice.
package kyber_pkg;

   localparam int KYBER_Q = 3329;
   localparam int COEF_W  = 12;
   localparam int KYBER_N = 256;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } sched_state_e;

   // Bits needed to hold any value in [0, max_val].
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/pwm_result_fifo.sv
// Synchronous result FIFO with occupancy count; used by pointwise_mult_sched
// only when PWM_SCHED_BP_EN is defined.
module pwm_result_fifo
   import kyber_pkg::*;
#(
   parameter int W     = 20,
   parameter int DEPTH = 6,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [W-1:0]     push_data,
   input  logic             pop,
   output logic [W-1:0]     head_data,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Depth need not be a power of two, so pointers wrap explicitly.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty     = (count == '0);
   assign do_push   = push && (count != CNT_W'(DEPTH));
   assign do_pop    = pop && !empty;
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pointwise_mult_sched.sv
// Pointwise polynomial multiply sequencer around the shared pipelined mod-q multiplier.
// Optional write backpressure with a result FIFO: define PWM_SCHED_BP_EN.
module pointwise_mult_sched
   import kyber_pkg::*;
#(
   parameter int N_COEF   = KYBER_N,
   parameter int ADDR_W   = 8,
   parameter int MULT_LAT = 4,
   parameter int FIFO_DEP = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [COEF_W-1:0] rd_a,
   input  logic [COEF_W-1:0] rd_b,
   output logic [COEF_W-1:0] mul_a,
   output logic [COEF_W-1:0] mul_b,
   input  logic [COEF_W-1:0] mul_res,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [COEF_W-1:0] wr_data,
   input  logic              wr_ready
);

   localparam int ISSUE_W = ADDR_W + 1;
   localparam int CNT_W   = cnt_width(FIFO_DEP + MULT_LAT + 1);

   sched_state_e       state;
   logic [ISSUE_W-1:0] issued;
   logic [MULT_LAT:1]  trk_vld;
   logic [ADDR_W-1:0]  trk_addr [1:MULT_LAT];
   logic [CNT_W-1:0]   in_flight;
   logic               tap_vld;
   logic [ADDR_W-1:0]  tap_addr;
   logic               can_issue;
   logic               pipe_empty;

   assign mul_a = rd_a;
   assign mul_b = rd_b;

   // The registered read strobe is stage 0; stage 1 lines up with mul_a/mul_b and
   // stage MULT_LAT with mul_res, so the tap names the address of the current product.
   assign tap_vld  = trk_vld[MULT_LAT];
   assign tap_addr = trk_addr[MULT_LAT];

   always_comb begin
      in_flight = CNT_W'(rd_en);
      for (int unsigned i = 1; i <= MULT_LAT; i++) begin
         in_flight = in_flight + CNT_W'(trk_vld[i]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         trk_vld <= '0;
         for (int unsigned i = 1; i <= MULT_LAT; i++) trk_addr[i] <= '0;
      end else begin
         trk_vld[1]  <= rd_en;
         trk_addr[1] <= rd_addr;
         for (int unsigned i = 2; i <= MULT_LAT; i++) begin
            trk_vld[i]  <= trk_vld[i-1];
            trk_addr[i] <= trk_addr[i-1];
         end
      end
   end

`ifdef PWM_SCHED_BP_EN
   logic [ADDR_W+COEF_W-1:0] fifo_head;
   logic                     fifo_empty;
   logic [CNT_W-1:0]         fifo_count;

   pwm_result_fifo #(
      .W     (ADDR_W + COEF_W),
      .DEPTH (FIFO_DEP),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (tap_vld),
      .push_data ({tap_addr, mul_res}),
      .pop       (wr_en & wr_ready),
      .head_data (fifo_head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign wr_en              = !fifo_empty;
   assign {wr_addr, wr_data} = fifo_empty ? '0 : fifo_head;

   // Every in-flight product already owns a FIFO slot, so the multiplier never
   // needs to stall.
   assign can_issue  = (in_flight + fifo_count) < CNT_W'(FIFO_DEP);
   assign pipe_empty = (in_flight == '0) && fifo_empty;
`else
   logic unused_wr_ready;
   assign unused_wr_ready = wr_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en   <= tap_vld;
         wr_addr <= tap_addr;
         wr_data <= mul_res;
      end
   end

   assign can_issue  = 1'b1;
   assign pipe_empty = (in_flight == '0);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         rd_en   <= 1'b0;
         rd_addr <= '0;
         issued  <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               // The first read goes out together with the transition into RUN.
               if (start) begin
                  state   <= RUN;
                  busy    <= 1'b1;
                  rd_en   <= 1'b1;
                  rd_addr <= '0;
                  issued  <= ISSUE_W'(1);
               end
            end
            RUN: begin
               if (issued == ISSUE_W'(N_COEF)) begin
                  state <= DRAIN;
                  rd_en <= 1'b0;
               end else if (can_issue) begin
                  rd_en   <= 1'b1;
                  rd_addr <= issued[ADDR_W-1:0];
                  issued  <= issued + 1'b1;
               end else begin
                  rd_en <= 1'b0;
               end
            end
            DRAIN: begin
               if (pipe_empty) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pointwise_mult_sched.sv
// Scoreboard bench for pointwise_mult_sched: sync RAM + latency multiplier model,
// expected c[i] = a[i]*b[i] mod 3329 queued at start, checked by a separate monitor.
module tb_pointwise_mult_sched;

   localparam int N  = 256;
   localparam int AW = 8;
   localparam int ML = 4;
   localparam int FD = 6;
   localparam int Q  = 3329;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          busy, done, rd_en, wr_en;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [11:0]   rd_a = '0, rd_b = '0;
   logic [11:0]   mul_a, mul_b, mul_res, wr_data;
   logic          wr_ready = 1'b1;

   always #5 clk = ~clk;

   pointwise_mult_sched #(
      .N_COEF   (N),
      .ADDR_W   (AW),
      .MULT_LAT (ML),
      .FIFO_DEP (FD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_a     (rd_a),
      .rd_b     (rd_b),
      .mul_a    (mul_a),
      .mul_b    (mul_b),
      .mul_res  (mul_res),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_ready (wr_ready)
   );

   // Coefficient RAM: registered read one cycle after rd_en.
   logic [11:0] mem_a [N];
   logic [11:0] mem_b [N];
   always @(posedge clk) begin
      if (rd_en) begin
         rd_a <= mem_a[rd_addr];
         rd_b <= mem_b[rd_addr];
      end
   end

   // Multiplier: the operand cycle counts as the first of ML, so the product
   // appears ML-1 clock edges after mul_a/mul_b are presented.
   logic [11:0] mpipe [ML-1];
   always @(posedge clk) begin
      mpipe[0] <= 12'((int'(mul_a) * int'(mul_b)) % Q);
      for (int i = 1; i < ML - 1; i++) mpipe[i] <= mpipe[i-1];
   end
   assign mul_res = mpipe[ML-2];

   typedef struct {
      int addr;
      int data;
   } exp_t;
   exp_t exp_q[$];

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int wr_cnt = 0, done_cnt = 0, iss_cnt = 0, acc_cnt = 0;
   int stall_end = 0;
   bit rand_rdy = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int expv);
      compared++;
      if (act != expv) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // wr_ready changes just after the rising edge so the monitor sees the value the DUT samples.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (cyc < stall_end)  wr_ready = 1'b0;
         else if (rand_rdy)    wr_ready = ($urandom_range(0, 9) >= 3);
         else                  wr_ready = 1'b1;
      end
   end

   // Monitor / scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         bit accepted;
`ifdef PWM_SCHED_BP_EN
         accepted = wr_en && wr_ready;
`else
         accepted = wr_en;
`endif
         if (rd_en) iss_cnt++;
         if (accepted) begin
            wr_cnt++;
            acc_cnt++;
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_write: addr %0d data %0d, expected no write", wr_addr, wr_data);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("wr_addr", int'(wr_addr), e.addr);
               check("wr_data", int'(wr_data), e.data);
            end
         end
         if (done) begin
            done_cnt++;
            check("pending_at_done", exp_q.size(), 0);
         end
`ifdef PWM_SCHED_BP_EN
         if (busy) begin
            compared++;
            if (iss_cnt - acc_cnt > FD) begin
               mismatched++;
               $display("FAIL outstanding: got %0d, expected <= %0d", iss_cnt - acc_cnt, FD);
            end
         end
`endif
      end
   end

   task automatic load(input int mode);
      for (int i = 0; i < N; i++) begin
         case (mode)
            0: begin mem_a[i] = 12'(i);    mem_b[i] = 12'd2;    end
            1: begin mem_a[i] = 12'd3328;  mem_b[i] = 12'd3328; end
            2: begin mem_a[i] = 12'd0;     mem_b[i] = 12'($urandom_range(0, Q - 1)); end
            default: begin
               mem_a[i] = 12'($urandom_range(0, Q - 1));
               mem_b[i] = 12'($urandom_range(0, Q - 1));
            end
         endcase
      end
   endtask

   task automatic push_expected();
      for (int i = 0; i < N; i++) begin
         exp_t e;
         e.addr = i;
         e.data = (int'(mem_a[i]) * int'(mem_b[i])) % Q;
         exp_q.push_back(e);
      end
   endtask

   task automatic run(input bit mid_start, input bit done_start, input int stall_at);
      int st;
      bit got;
      got = 1'b0;
      push_expected();
      wr_cnt = 0; done_cnt = 0; iss_cnt = 0; acc_cnt = 0;
      @(negedge clk);
      start = 1'b1;
      st = cyc;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
`ifndef PWM_SCHED_BP_EN
            check("done_latency", cyc - st, N + 2 + ML);
`endif
            break;
         end
         start = mid_start && (n == 50);
         if (stall_at > 0 && n == stall_at) stall_end = cyc + 52;
         if (stall_at > 0 && n == stall_at + 45) begin
            check("rd_en_in_stall", rd_en, 0);
            check("outstanding_full", iss_cnt - acc_cnt, FD);
            check("busy_in_stall", busy, 1);
         end
      end
      if (!got) begin
         compared++;
         mismatched++;
         $display("FAIL done_timeout: got no done, expected done within 4000 cycles");
      end
      start = done_start;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      check("write_count", wr_cnt, N);
      check("done_pulses", done_cnt, 1);
      check("busy_idle", busy, 0);
      check("queue_drained", exp_q.size(), 0);
   endtask

   task automatic run_with_reset();
      bit hit;
      hit = 1'b0;
      push_expected();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         if (rd_en && rd_addr == AW'(100)) begin
            hit = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("reached_issue_100", hit, 1);
      rst = 1'b0;
      exp_q.delete();
      repeat (2) begin
         @(negedge clk);
         check("wr_en_in_reset", wr_en, 0);
      end
      check("busy_in_reset", busy, 0);
      check("rd_en_in_reset", rd_en, 0);
      check("done_in_reset", done, 0);
      rst = 1'b1;
      wr_cnt = 0;
      repeat (12) @(negedge clk);
      check("writes_after_reset", wr_cnt, 0);
      check("busy_after_reset", busy, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_en", rd_en, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_rd_addr", int'(rd_addr), 0);
      check("rst_wr_addr", int'(wr_addr), 0);
      check("rst_wr_data", int'(wr_data), 0);
      rst = 1'b1;

      load(0); run(1'b0, 1'b0, 0);
`ifndef PWM_SCHED_BP_EN
      rand_rdy = 1'b1;
`endif
      load(1); run(1'b0, 1'b0, 0);
      rand_rdy = 1'b0;
      load(2); run(1'b1, 1'b1, 0);
      load(3); run_with_reset();
      run(1'b0, 1'b0, 0);
`ifdef PWM_SCHED_BP_EN
      rand_rdy = 1'b1;
      load(3); run(1'b0, 1'b0, 0);
      rand_rdy = 1'b0;
      load(3); run(1'b0, 1'b0, 60);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
